// File: rtl/match_issuer_if.sv
// Request/response channel plus match-unit operand/result bus for match_issuer.
// slave is the issuer side; master is the sequencer and match-unit side.
interface match_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [7:0]  xout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_kind;
  logic        rsp_err;
  logic [15:0] count;
  logic [15:0] err_count;

  modport slave (
    input  req_valid, req_a, req_b, xout, rsp_ready,
    output req_ready, a, b, rsp_valid, rsp_data, rsp_kind, rsp_err, count, err_count
  );

  modport master (
    output req_valid, req_a, req_b, xout, rsp_ready,
    input  req_ready, a, b, rsp_valid, rsp_data, rsp_kind, rsp_err, count, err_count
  );
endinterface

// File: rtl/match_issuer.sv
// Sequential initiator for the 8-bit opcode-match unit: drives A/B, waits SETTLE
// cycles, checks XOUT against its own expected value and returns it as a response.
//   state | meaning
//   IDLE  | ready for a request; A/B keep the last operands
//   DRIVE | operands held on A/B while the settle counter runs down
//   RESP  | response presented, waiting for rsp_ready
module match_issuer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  match_issuer_if.slave bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
    $error("match_issuer: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [1:0]  kind_q, kind_d;
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] count_q, count_d;
  logic [15:0] err_count_q, err_count_d;

  logic [1:0]  req_kind;
  logic [7:0]  req_exp;

  // Opcode decode and expected result, all mod 2^8.
  always_comb begin
    req_kind = 2'd3;
    req_exp  = bus.req_a * bus.req_b;
    case (bus.req_a)
      8'd17: begin req_kind = 2'd0; req_exp = bus.req_a + 8'd1;      end
      8'd21: begin req_kind = 2'd1; req_exp = bus.req_a + bus.req_b; end
      8'd34: begin req_kind = 2'd2; req_exp = bus.req_a - bus.req_b; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    exp_d       = exp_q;
    kind_d      = kind_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          kind_d  = req_kind;
          exp_d   = req_exp;
          cnt_d   = SETTLE_L;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_data_d = bus.xout;
          err_d      = (bus.xout != exp_q);
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          count_d = count_q + 16'd1;
          if (err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      exp_q       <= 8'h00;
      kind_q      <= 2'd0;
      rsp_data_q  <= 8'h00;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
      count_q     <= 16'h0000;
      err_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exp_q       <= exp_d;
      kind_q      <= kind_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_kind  = kind_q;
  assign bus.rsp_err   = err_q;
  assign bus.count     = count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_match_issuer.sv
// Directed bench for match_issuer: vector table on a SETTLE=1 instance, plus
// hand sequences for saturation, backpressure (SETTLE=3), mid-op reset and COUNT wrap.
module tb_match_issuer;

  logic clk = 1'b0;
  logic rst_n;
  logic xzero1 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  match_issuer_if bus1 ();
  match_issuer_if bus3 ();

  function automatic logic [7:0] ideal(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (a)
      8'd17:   return 8'(a + 8'd1);
      8'd21:   return 8'(a + b);
      8'd34:   return 8'(a - b);
      default: return p[7:0];
    endcase
  endfunction

  assign bus1.xout = xzero1 ? 8'h00 : ideal(bus1.a, bus1.b);
  assign bus3.xout = ideal(bus3.a, bus3.b);

  match_issuer #(.SETTLE(1)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  match_issuer #(.SETTLE(3)) u_dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(bus3));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       zero;
    logic [7:0] data;
    logic [1:0] kind;
    logic       err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic zero,
                      output logic [7:0] d, output logic [1:0] k, output logic e,
                      output logic [7:0] ao, output logic [7:0] bo, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus1.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("run1_ready", 32'(bus1.req_ready), 32'd1);
    bus1.req_valid = 1'b1;
    bus1.req_a     = a;
    bus1.req_b     = b;
    xzero1         = zero;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    lat = 0;
    while (!bus1.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d  = bus1.rsp_data;
    k  = bus1.rsp_kind;
    e  = bus1.rsp_err;
    ao = bus1.a;
    bo = bus1.b;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    xzero1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, ao, bo;
    logic [1:0]  k;
    logic        e;
    int          lat;
    logic [15:0] exp_cnt, exp_err;

    vecs[0]  = '{8'd17,  8'd5,   1'b0, 8'd18,  2'd0, 1'b0};
    vecs[1]  = '{8'd21,  8'd200, 1'b0, 8'd221, 2'd1, 1'b0};
    vecs[2]  = '{8'd34,  8'd40,  1'b0, 8'd250, 2'd2, 1'b0};
    vecs[3]  = '{8'd3,   8'd100, 1'b0, 8'd44,  2'd3, 1'b0};
    vecs[4]  = '{8'd255, 8'd255, 1'b0, 8'd1,   2'd3, 1'b0};
    vecs[5]  = '{8'd17,  8'd255, 1'b0, 8'd18,  2'd0, 1'b0};
    vecs[6]  = '{8'd21,  8'd250, 1'b0, 8'd15,  2'd1, 1'b0};
    vecs[7]  = '{8'd34,  8'd34,  1'b0, 8'd0,   2'd2, 1'b0};
    vecs[8]  = '{8'd16,  8'd16,  1'b0, 8'd0,   2'd3, 1'b0};
    vecs[9]  = '{8'd0,   8'd77,  1'b0, 8'd0,   2'd3, 1'b0};
    vecs[10] = '{8'd17,  8'd5,   1'b1, 8'd0,   2'd0, 1'b1};

    bus1.req_valid = 1'b0; bus1.req_a = 8'h00; bus1.req_b = 8'h00; bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_a = 8'h00; bus3.req_b = 8'h00; bus3.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rst_a",         32'(bus1.a),         32'd0);
    chk("rst_b",         32'(bus1.b),         32'd0);
    chk("rst_rsp_data",  32'(bus1.rsp_data),  32'd0);
    chk("rst_rsp_kind",  32'(bus1.rsp_kind),  32'd0);
    chk("rst_rsp_err",   32'(bus1.rsp_err),   32'd0);
    chk("rst_count",     32'(bus1.count),     32'd0);
    chk("rst_err_count", 32'(bus1.err_count), 32'd0);
    chk("rst3_req_ready", 32'(bus3.req_ready), 32'd1);
    rst_n = 1'b1;

    exp_cnt = 16'd0;
    exp_err = 16'd0;
    for (int i = 0; i < 11; i++) begin
      run1(vecs[i].a, vecs[i].b, vecs[i].zero, d, k, e, ao, bo, lat);
      exp_cnt = exp_cnt + 16'd1;
      if (vecs[i].err) exp_err = exp_err + 16'd1;
      chk($sformatf("v%0d_data", i),  32'(d),   32'(vecs[i].data));
      chk($sformatf("v%0d_kind", i),  32'(k),   32'(vecs[i].kind));
      chk($sformatf("v%0d_err", i),   32'(e),   32'(vecs[i].err));
      chk($sformatf("v%0d_lat", i),   32'(lat), 32'd1);
      chk($sformatf("v%0d_a", i),     32'(ao),  32'(vecs[i].a));
      chk($sformatf("v%0d_b", i),     32'(bo),  32'(vecs[i].b));
      chk($sformatf("v%0d_count", i), 32'(bus1.count),     32'(exp_cnt));
      chk($sformatf("v%0d_errcnt", i), 32'(bus1.err_count), 32'(exp_err));
    end
    chk("idle_keeps_a", 32'(bus1.a), 32'd17);
    chk("idle_keeps_b", 32'(bus1.b), 32'd5);

    // ERR_COUNT saturation
    @(negedge clk);
    force u_dut1.err_count_q = 16'hFFFF;
    @(negedge clk);
    release u_dut1.err_count_q;
    chk("sat_preload", 32'(bus1.err_count), 32'hFFFF);
    run1(8'd17, 8'd5, 1'b1, d, k, e, ao, bo, lat);
    chk("sat_err", 32'(e), 32'd1);
    chk("sat_err_count", 32'(bus1.err_count), 32'hFFFF);
    chk("sat_count", 32'(bus1.count), 32'(exp_cnt + 16'd1));

    // Backpressure on the SETTLE=3 instance
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_a = 8'd34; bus3.req_b = 8'd40;
    @(negedge clk);
    bus3.req_valid = 1'b0;
    lat = 0;
    while (!bus3.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus3.req_valid = 1'b1; bus3.req_a = 8'd17; bus3.req_b = 8'd5;
      end else begin
        bus3.req_valid = 1'b0;
      end
      chk($sformatf("bp%0d_valid", c), 32'(bus3.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_data", c),  32'(bus3.rsp_data),  32'd250);
      chk($sformatf("bp%0d_kind", c),  32'(bus3.rsp_kind),  32'd2);
      chk($sformatf("bp%0d_a", c),     32'(bus3.a),         32'd34);
      chk($sformatf("bp%0d_b", c),     32'(bus3.b),         32'd40);
      chk($sformatf("bp%0d_ready", c), 32'(bus3.req_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_after_a", 32'(bus3.a), 32'd34);
    chk("bp_after_data", 32'(bus3.rsp_data), 32'd250);
    bus3.rsp_ready = 1'b1;
    bus3.req_valid = 1'b1; bus3.req_a = 8'd21; bus3.req_b = 8'd1;
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    chk("bp_hs_valid", 32'(bus3.rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(bus3.req_ready), 32'd1);
    chk("bp_hs_count", 32'(bus3.count),     32'd1);
    chk("bp_hs_a",     32'(bus3.a),         32'd34);
    @(negedge clk);
    bus3.req_valid = 1'b0;
    chk("bp_acc_ready", 32'(bus3.req_ready), 32'd0);
    chk("bp_acc_a",     32'(bus3.a),         32'd21);
    chk("bp_acc_b",     32'(bus3.b),         32'd1);
    lat = 0;
    while (!bus3.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp2_lat",  32'(lat), 32'd3);
    chk("bp2_data", 32'(bus3.rsp_data), 32'd22);
    chk("bp2_kind", 32'(bus3.rsp_kind), 32'd1);
    bus3.rsp_ready = 1'b1;
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    chk("bp2_count", 32'(bus3.count), 32'd2);
    chk("bp2_err_count", 32'(bus3.err_count), 32'd0);

    // Reset during DRIVE
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_a = 8'd21; bus1.req_b = 8'd3;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    chk("rd_in_drive", 32'(bus1.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rd_req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rd_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rd_a",         32'(bus1.a),         32'd0);
    chk("rd_b",         32'(bus1.b),         32'd0);
    chk("rd_count",     32'(bus1.count),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run1(8'd21, 8'd3, 1'b0, d, k, e, ao, bo, lat);
    chk("rd_next_data", 32'(d), 32'd24);
    chk("rd_next_lat",  32'(lat), 32'd1);
    chk("rd_next_count", 32'(bus1.count), 32'd1);

    // Reset during RESP
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_a = 8'd34; bus1.req_b = 8'd1;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("rr_in_resp", 32'(bus1.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rr_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("rr_a",         32'(bus1.a),         32'd0);
    chk("rr_b",         32'(bus1.b),         32'd0);
    chk("rr_count",     32'(bus1.count),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run1(8'd3, 8'd3, 1'b0, d, k, e, ao, bo, lat);
    chk("rr_next_data", 32'(d), 32'd9);
    chk("rr_next_kind", 32'(k), 32'd3);
    chk("rr_next_count", 32'(bus1.count), 32'd1);

    // COUNT wrap, starting near the top of the range
    @(negedge clk);
    force u_dut1.count_q = 16'hFFFE;
    @(negedge clk);
    release u_dut1.count_q;
    run1(8'd21, 8'd4, 1'b0, d, k, e, ao, bo, lat);
    chk("wrap_count_ffff", 32'(bus1.count), 32'hFFFF);
    run1(8'd34, 8'd4, 1'b0, d, k, e, ao, bo, lat);
    chk("wrap_data", 32'(d), 32'd30);
    chk("wrap_count_zero", 32'(bus1.count), 32'd0);
    chk("wrap_err_count", 32'(bus1.err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
